instr_fetch_unit: RTL and testbench

//  Fetch stage that sits directly upstream of the execute/ALU stage. Holds the 5-bit PC and

---
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage feeding the execute/ALU stage. Owns the PC and issues reads to
//   a synchronous instruction memory (data returns one cycle after the read).
//   Each returned word is tagged with its PC and queued in a 2-entry buffer.
//   The head entry is presented to execute with its fields pre-split, over a
//   valid/ready handshake. Execute can redirect the PC at any time. Fetching
//   stops once a HALT opcode has been queued. When execute accepts the HALT,
//   halted is raised and stays high until a redirect or a reset.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-low
//   imem_rd_en      instruction memory read request (this cycle)
//   imem_addr       read address (current PC)
//   imem_data       read data, valid the cycle after imem_rd_en
//   redirect_valid  one-cycle request from execute to change the PC
//   redirect_pc     new PC for the redirect
//   out_valid       head instruction available
//   out_ready       execute accepts the head this cycle
//   out_instr       raw head instruction (0 when out_valid=0)
//   out_pc          PC of the head instruction (0 when out_valid=0)
//   out_opcode/out_rd/out_rs/out_rt/out_shamt/out_func/out_imm
//                   decoded fields of out_instr
//   halted          a HALT instruction has been accepted by execute
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                ADDR_W      = 5,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [5:0]        HALT_OPCODE = 6'd63
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_rd_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [5:0]        out_opcode,
   output logic [4:0]        out_rd,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_shamt,
   output logic [5:0]        out_func,
   output logic [15:0]       out_imm,
   output logic              halted
);

   typedef enum logic [1:0] {FETCH, HALT_WAIT, HALTED} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic              vld_p1;
   logic [ADDR_W-1:0] pc_p1;
   logic [1:0]        count;
   logic [DATA_W-1:0] buf_instr_p2 [2];
   logic [ADDR_W-1:0] buf_pc_p2    [2];

   logic              pop, push, push_halt, head_halt, room, issue;
   logic [1:0]        wr_idx;

   function automatic logic is_halt(input logic [DATA_W-1:0] word);
      return word[31:26] == HALT_OPCODE;
   endfunction

   // ---------------------------------------------------------------------------
   // Control: handshake, issue and buffer bookkeeping
   // ---------------------------------------------------------------------------
   assign out_valid = (count != 2'd0);
   assign pop       = out_valid && out_ready;
   // A redirect discards whatever the memory returns this cycle.
   assign push      = vld_p1 && !redirect_valid;
   assign push_halt = push && is_halt(imem_data);
   assign head_halt = is_halt(buf_instr_p2[0]);
   assign room      = ({1'b0, count} + {2'b00, vld_p1}) < 3'd2;

   // A HALT word arriving this cycle also blocks this cycle's issue. Without
   // that block, the word after the HALT would already be in flight.
   assign issue = reset && (state == FETCH) && !redirect_valid && !push_halt &&
                  (room || pop);

   assign imem_rd_en = issue;
   assign imem_addr  = pc;
   assign halted     = (state == HALTED);

   // After a pop the surviving entry moves to slot 0, so a push lands at count-pop.
   assign wr_idx = count - {1'b0, pop};

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = FETCH;
      end else begin
         unique case (state)
            FETCH:     if (push_halt)         state_nxt = HALT_WAIT;
            HALT_WAIT: if (pop && head_halt)  state_nxt = HALTED;
            HALTED:                           state_nxt = HALTED;
            default:                          state_nxt = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= FETCH;
         pc     <= RESET_PC;
         vld_p1 <= 1'b0;
         count  <= 2'd0;
      end else begin
         state <= state_nxt;
         if (redirect_valid) begin
            pc     <= redirect_pc;
            vld_p1 <= 1'b0;
            count  <= 2'd0;
         end else begin
            vld_p1 <= issue;
            if (issue) pc <= pc + ADDR_W'(1);
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   // ---------------------------------------------------------------------------
   // p0 -> p1: request PC captured so the returning word can be tagged
   // p1 -> p2: returning word written into the 2-entry buffer
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (issue) pc_p1 <= pc;
      if (pop) begin
         buf_instr_p2[0] <= buf_instr_p2[1];
         buf_pc_p2[0]    <= buf_pc_p2[1];
      end
      if (push) begin
         if (wr_idx == 2'd0) begin
            buf_instr_p2[0] <= imem_data;
            buf_pc_p2[0]    <= pc_p1;
         end else begin
            buf_instr_p2[1] <= imem_data;
            buf_pc_p2[1]    <= pc_p1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // p2 -> execute: head entry with fields forced to zero when not valid
   // ---------------------------------------------------------------------------
   assign out_instr  = out_valid ? buf_instr_p2[0] : '0;
   assign out_pc     = out_valid ? buf_pc_p2[0]    : '0;
   assign out_opcode = out_instr[31:26];
   assign out_rd     = out_instr[25:21];
   assign out_rs     = out_instr[20:16];
   assign out_rt     = out_instr[15:11];
   assign out_shamt  = out_instr[10:6];
   assign out_func   = out_instr[5:0];
   assign out_imm    = out_instr[15:0];

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                   !(push && (count == 2'd2) && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed cycle-by-cycle bench for instr_fetch_unit. It uses a synchronous
//   32-word instruction memory model. All expected values are hand-computed
//   constants.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_rd_en;
   logic [4:0]  imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [4:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [4:0]  out_pc;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rd, out_rs, out_rt, out_shamt;
   logic [5:0]  out_func;
   logic [15:0] out_imm;
   logic        halted;

   logic [31:0] mem [32];
   int          n_cmp = 0;
   int          n_mis = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_rd_en     (imem_rd_en),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_opcode     (out_opcode),
      .out_rd         (out_rd),
      .out_rs         (out_rs),
      .out_rt         (out_rt),
      .out_shamt      (out_shamt),
      .out_func       (out_func),
      .out_imm        (out_imm),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_rd_en) imem_data <= mem[imem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic exp_rd(input string tag, input logic en, input logic [4:0] addr);
      chk({tag, ".rd_en"}, 32'(imem_rd_en), 32'(en));
      if (en) chk({tag, ".addr"}, 32'(imem_addr), 32'(addr));
   endtask

   task automatic exp_out(input string tag, input logic vld, input logic [4:0] pc,
                          input logic [31:0] instr);
      chk({tag, ".valid"}, 32'(out_valid), 32'(vld));
      chk({tag, ".pc"},    32'(out_pc),    32'(pc));
      chk({tag, ".instr"}, out_instr,      instr);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h2000_0000 | i;
      mem[0]  = 32'h00A0_0800;
      mem[1]  = 32'h04A1_0800;
      mem[2]  = 32'h0800_0000;
      mem[3]  = 32'h0C00_0000;
      mem[31] = 32'h0000_0000;

      reset          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 5'd0;
      repeat (3) cyc();
      #1;
      exp_rd("rst", 1'b0, 5'd0);
      exp_out("rst", 1'b0, 5'd0, 32'h0);
      chk("rst.halted", 32'(halted), 32'd0);
      chk("rst.rd_fld", 32'(out_rd), 32'd0);

      // Reset release, back-to-back stream
      cyc(); reset = 1'b1; out_ready = 1'b1; #1;
      exp_rd("c1", 1'b1, 5'd0);  exp_out("c1", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c2", 1'b1, 5'd1);  exp_out("c2", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c3", 1'b1, 5'd2);  exp_out("c3", 1'b1, 5'd0, 32'h00A0_0800);
      chk("c3.opcode", 32'(out_opcode), 32'd0);
      chk("c3.rd",     32'(out_rd),     32'd5);
      chk("c3.rs",     32'(out_rs),     32'd0);
      chk("c3.rt",     32'(out_rt),     32'd1);
      chk("c3.shamt",  32'(out_shamt),  32'd0);
      chk("c3.func",   32'(out_func),   32'd0);
      chk("c3.imm",    32'(out_imm),    32'h0800);
      cyc(); #1;
      exp_rd("c4", 1'b1, 5'd3);  exp_out("c4", 1'b1, 5'd1, 32'h04A1_0800);
      chk("c4.opcode", 32'(out_opcode), 32'd1);
      chk("c4.rs",     32'(out_rs),     32'd1);
      cyc(); #1;
      exp_rd("c5", 1'b1, 5'd4);  exp_out("c5", 1'b1, 5'd2, 32'h0800_0000);

      // Redirect to 0 while popping PC 3; in-flight PC 4 must vanish
      cyc(); redirect_valid = 1'b1; redirect_pc = 5'd0; #1;
      exp_rd("c6", 1'b0, 5'd0);  exp_out("c6", 1'b1, 5'd3, 32'h0C00_0000);
      cyc(); redirect_valid = 1'b0; out_ready = 1'b0; #1;
      exp_rd("c7", 1'b1, 5'd0);  exp_out("c7", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c8", 1'b1, 5'd1);  exp_out("c8", 1'b0, 5'd0, 32'h0);

      // Stall: buffer fills, issue stops, head held
      cyc(); #1;
      exp_rd("c9", 1'b0, 5'd0);  exp_out("c9", 1'b1, 5'd0, 32'h00A0_0800);
      for (int k = 0; k < 4; k++) begin
         cyc(); #1;
         exp_rd("stall", 1'b0, 5'd0);  exp_out("stall", 1'b1, 5'd0, 32'h00A0_0800);
      end
      cyc(); out_ready = 1'b1; #1;
      exp_rd("c14", 1'b1, 5'd2); exp_out("c14", 1'b1, 5'd0, 32'h00A0_0800);
      cyc(); #1;
      exp_rd("c15", 1'b1, 5'd3); exp_out("c15", 1'b1, 5'd1, 32'h04A1_0800);
      cyc(); #1;
      exp_rd("c16", 1'b1, 5'd4); exp_out("c16", 1'b1, 5'd2, 32'h0800_0000);

      // Redirect to 20 with the buffer full
      cyc(); out_ready = 1'b0; #1;
      exp_rd("c17", 1'b0, 5'd0); exp_out("c17", 1'b1, 5'd3, 32'h0C00_0000);
      cyc(); redirect_valid = 1'b1; redirect_pc = 5'd20; #1;
      exp_rd("c18", 1'b0, 5'd0); exp_out("c18", 1'b1, 5'd3, 32'h0C00_0000);
      cyc(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
      exp_rd("c19", 1'b1, 5'd20); exp_out("c19", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c20", 1'b1, 5'd21); exp_out("c20", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c21", 1'b1, 5'd22); exp_out("c21", 1'b1, 5'd20, 32'h2000_0014);

      // PC wrap 30, 31, 0
      cyc(); redirect_valid = 1'b1; redirect_pc = 5'd30; #1;
      exp_rd("c22", 1'b0, 5'd0);  exp_out("c22", 1'b1, 5'd21, 32'h2000_0015);
      cyc(); redirect_valid = 1'b0; #1;
      exp_rd("c23", 1'b1, 5'd30); exp_out("c23", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c24", 1'b1, 5'd31); exp_out("c24", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c25", 1'b1, 5'd0);  exp_out("c25", 1'b1, 5'd30, 32'h2000_001E);
      cyc(); #1;
      exp_rd("c26", 1'b1, 5'd1);  exp_out("c26", 1'b1, 5'd31, 32'h0);
      cyc(); #1;
      exp_rd("c27", 1'b1, 5'd2);  exp_out("c27", 1'b1, 5'd0, 32'h00A0_0800);

      // HALT at PC 2
      cyc(); mem[2] = 32'hFC00_0000; redirect_valid = 1'b1; redirect_pc = 5'd0; #1;
      exp_rd("c28", 1'b0, 5'd0);  exp_out("c28", 1'b1, 5'd1, 32'h04A1_0800);
      cyc(); redirect_valid = 1'b0; #1;
      exp_rd("c29", 1'b1, 5'd0);  exp_out("c29", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c30", 1'b1, 5'd1);
      cyc(); #1;
      exp_rd("c31", 1'b1, 5'd2);  exp_out("c31", 1'b1, 5'd0, 32'h00A0_0800);
      cyc(); #1;
      exp_rd("c32", 1'b0, 5'd0);  exp_out("c32", 1'b1, 5'd1, 32'h04A1_0800);
      chk("c32.halted", 32'(halted), 32'd0);
      cyc(); #1;
      exp_rd("c33", 1'b0, 5'd0);  exp_out("c33", 1'b1, 5'd2, 32'hFC00_0000);
      chk("c33.opcode", 32'(out_opcode), 32'd63);
      chk("c33.halted", 32'(halted), 32'd0);
      cyc(); #1;
      exp_rd("c34", 1'b0, 5'd0);  exp_out("c34", 1'b0, 5'd0, 32'h0);
      chk("c34.halted", 32'(halted), 32'd1);
      cyc(); redirect_valid = 1'b1; redirect_pc = 5'd0; #1;
      exp_rd("c35", 1'b0, 5'd0);
      chk("c35.halted", 32'(halted), 32'd1);
      cyc(); redirect_valid = 1'b0; #1;
      exp_rd("c36", 1'b1, 5'd0);  exp_out("c36", 1'b0, 5'd0, 32'h0);
      chk("c36.halted", 32'(halted), 32'd0);

      // One-cycle reset with PC 0 in flight
      cyc(); reset = 1'b0; #1;
      exp_rd("c37", 1'b0, 5'd0);
      cyc(); reset = 1'b1; #1;
      exp_rd("c38", 1'b1, 5'd0);  exp_out("c38", 1'b0, 5'd0, 32'h0);
      chk("c38.halted", 32'(halted), 32'd0);
      cyc(); #1;
      exp_rd("c39", 1'b1, 5'd1);  exp_out("c39", 1'b0, 5'd0, 32'h0);
      cyc(); #1;
      exp_rd("c40", 1'b1, 5'd2);  exp_out("c40", 1'b1, 5'd0, 32'h00A0_0800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
